// File: rtl/button_event_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_event_decoder_pkg
// Purpose  : Shared definitions for the button event decoder.
//            - FSM state encoding (3-bit): IDLE, PRESSED, GAP, SECOND, LONG.
//            - Default timing constants in clk cycles for a 25 MHz board clock.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package button_event_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,  // waiting for a press
    ST_PRESSED = 3'd1,  // first press held, timing towards a long press
    ST_GAP     = 3'd2,  // released, timing the double-click window
    ST_SECOND  = 3'd3,  // second press of a double click held
    ST_LONG    = 3'd4   // long press qualified, waiting for release
  } btn_state_t;

  // 25 MHz board clock
  localparam int DEF_CNT_WIDTH         = 24;
  localparam int DEF_LONG_PRESS_CYCLES = 12_500_000;  // 0.5 s
  localparam int DEF_DOUBLE_GAP_CYCLES = 6_250_000;   // 0.25 s
  localparam int DEF_REPEAT_CYCLES     = 2_500_000;   // 0.1 s

endpackage : button_event_decoder_pkg
`default_nettype wire

// File: rtl/button_event_decoder_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : button_event_decoder_edge_detect
// Purpose  : Registers the switch level once and derives rise/fall strobes
//            from the live level against the registered copy.
// Ports    : clk      in  system clock
//            rst_n    in  asynchronous active-low reset
//            i_Level  in  debounced level, synchronous to clk
//            o_Rise   out combinational: i_Level & ~prev
//            o_Fall   out combinational: ~i_Level & prev
//            o_Level  out registered copy of i_Level (prev)
// Revision : 1.0 - initial release
// ============================================================================
module button_event_decoder_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_Level,
  output logic o_Rise,
  output logic o_Fall,
  output logic o_Level
);

  logic level_q;

  // prev resets to 0 so a switch already held at reset release reads as a rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= i_Level;
    end
  end

  assign o_Rise  =  i_Level & ~level_q;
  assign o_Fall  = ~i_Level &  level_q;
  assign o_Level =  level_q;

endmodule : button_event_decoder_edge_detect
`default_nettype wire

// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : button_event_decoder
// Purpose  : Turns a debounced switch level into one-cycle event pulses:
//            press, release, single click, double click, long press and
//            (optionally) auto-repeat while long-held.
//            Optional feature macro: BUTTON_REPEAT_EN enables o_Repeat.
//            Without it o_Repeat is constant 0 and no LONG timing exists.
// Ports    : clk       in  system clock
//            rst_n     in  asynchronous active-low reset
//            i_Switch  in  debounced level, synchronous to clk (1 = pressed)
//            o_Held    out registered copy of i_Switch
//            o_Press   out pulse on every 0->1 of i_Switch
//            o_Release out pulse on every 1->0 of i_Switch
//            o_Click   out pulse: single short press confirmed (gap expired)
//            o_Double  out pulse: second press arrived within the gap
//            o_Long    out pulse: hold reached LONG_PRESS_CYCLES
//            o_Repeat  out auto-repeat pulse while long-held
// Revision : 1.0 - initial release
// ============================================================================
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int CNT_WIDTH         = DEF_CNT_WIDTH,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int DOUBLE_GAP_CYCLES = DEF_DOUBLE_GAP_CYCLES,
  parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_Switch,
  output logic o_Held,
  output logic o_Press,
  output logic o_Release,
  output logic o_Click,
  output logic o_Double,
  output logic o_Long,
  output logic o_Repeat
);

  localparam longint MAX_COUNT = (longint'(1) << CNT_WIDTH) - 1;

  // Every timing threshold must be at least one cycle and fit the timer
  if (LONG_PRESS_CYCLES < 1 || DOUBLE_GAP_CYCLES < 1 || REPEAT_CYCLES < 1 ||
      longint'(LONG_PRESS_CYCLES) > MAX_COUNT ||
      longint'(DOUBLE_GAP_CYCLES) > MAX_COUNT ||
      longint'(REPEAT_CYCLES)     > MAX_COUNT) begin : g_bad_params
    $fatal(1, "button_event_decoder: timing parameter out of range for CNT_WIDTH");
  end

  // The timer reads 0 in the cycle after state entry, so a threshold of N
  // cycles is reached when the timer shows N-1.
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(DOUBLE_GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMER_MAX = '1;
`ifdef BUTTON_REPEAT_EN
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
`endif

  logic rise;
  logic fall;

  btn_state_t           state;
  logic [CNT_WIDTH-1:0] timer;
  logic                 press_q;
  logic                 release_q;
  logic                 click_q;
  logic                 double_q;
  logic                 long_q;
`ifdef BUTTON_REPEAT_EN
  logic                 repeat_q;
`endif

  button_event_decoder_edge_detect u_edge_detect (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_Level (i_Switch),
    .o_Rise  (rise),
    .o_Fall  (fall),
    .o_Level (o_Held)
  );

  // Single registered FSM. Edges are tested before timer expiries in every
  // state, so an edge always wins a same-cycle race with a threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
`ifdef BUTTON_REPEAT_EN
      repeat_q  <= 1'b0;
`endif
    end else begin
      // Press/release follow the raw edges independent of state
      press_q   <= rise;
      release_q <= fall;
      click_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
`ifdef BUTTON_REPEAT_EN
      repeat_q  <= 1'b0;
`endif

      // Saturating count; states that are not timed or that change state
      // override this with a clear below.
      if (timer != TIMER_MAX) begin
        timer <= timer + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (rise) begin
            state <= ST_PRESSED;
          end
        end

        ST_PRESSED: begin
          if (fall) begin
            state <= ST_GAP;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            state  <= ST_LONG;
            timer  <= '0;
            long_q <= 1'b1;
          end
        end

        ST_GAP: begin
          if (rise) begin
            state    <= ST_SECOND;
            timer    <= '0;
            double_q <= 1'b1;
          end else if (timer == GAP_LAST) begin
            state   <= ST_IDLE;
            timer   <= '0;
            click_q <= 1'b1;
          end
        end

        ST_SECOND: begin
          timer <= '0;
          if (fall) begin
            state <= ST_IDLE;
          end
        end

        ST_LONG: begin
`ifdef BUTTON_REPEAT_EN
          if (fall) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (timer == REPEAT_LAST) begin
            timer    <= '0;  // restart the period at every pulse
            repeat_q <= 1'b1;
          end
`else
          timer <= '0;
          if (fall) begin
            state <= ST_IDLE;
          end
`endif
        end

        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Click   = click_q;
  assign o_Double  = double_q;
  assign o_Long    = long_q;
`ifdef BUTTON_REPEAT_EN
  assign o_Repeat  = repeat_q;
`else
  assign o_Repeat  = 1'b0;
`endif

endmodule : button_event_decoder
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_decoder
// Purpose  : Self-checking bench for button_event_decoder. Stimulus pushes
//            hand-computed (cycle, pulse-vector) expectations into a sorted
//            queue; a monitor on the falling edge compares every cycle's
//            pulse outputs against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_decoder;

  localparam int LONG_N = 20;
  localparam int GAP_N  = 10;
  localparam int REP_N  = 5;

  // pulse vector order: {repeat, long, double, click, release, press}
  localparam logic [5:0] E_PRESS = 6'b000001;
  localparam logic [5:0] E_REL   = 6'b000010;
  localparam logic [5:0] E_CLICK = 6'b000100;
  localparam logic [5:0] E_DBL   = 6'b001000;
  localparam logic [5:0] E_LONG  = 6'b010000;
  localparam logic [5:0] E_REP   = 6'b100000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sw    = 1'b0;
  logic held, press, rel, click, dbl, lng, rep;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [5:0] bits;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  button_event_decoder #(
    .CNT_WIDTH         (8),
    .LONG_PRESS_CYCLES (LONG_N),
    .DOUBLE_GAP_CYCLES (GAP_N),
    .REPEAT_CYCLES     (REP_N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_Switch  (sw),
    .o_Held    (held),
    .o_Press   (press),
    .o_Release (rel),
    .o_Click   (click),
    .o_Double  (dbl),
    .o_Long    (lng),
    .o_Repeat  (rep)
  );

  // Insert keeping the queue sorted by cycle; same-cycle events merge.
  task automatic expect_ev(input int at, input logic [5:0] bits);
    int idx;
    idx = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].at == at) begin
        exp_q[i].bits = exp_q[i].bits | bits;
        return;
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].at > at) begin
        idx = i;
        break;
      end
    end
    exp_q.insert(idx, '{at: at, bits: bits});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string name);
    logic [6:0] act;
    act = {held, rep, lng, dbl, click, rel, press};
    total++;
    if (act !== 7'b0) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%b required=0000000", name, cyc, act);
    end
  endtask

  task automatic check_held(input logic want, input string name);
    total++;
    if (held !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, held, want);
    end
  endtask

  // Monitor: every falling edge, the pulse outputs must match the queued
  // expectation for this cycle, or be all zero when none is queued.
  always @(negedge clk) begin
    logic [5:0] act;
    exp_t       e;
    act = {rep, lng, dbl, click, rel, press};
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missed_event cyc=%0d actual=none required=%b", e.at, e.bits);
    end
    if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      e = exp_q.pop_front();
      total++;
      if (act !== e.bits) begin
        bad++;
        $display("FAIL event cyc=%0d actual=%b required=%b", cyc, act, e.bits);
      end
    end else if (act !== 6'b0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event cyc=%0d actual=%b required=000000", cyc, act);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int r;

    // 1. Reset held while the switch toggles: everything stays 0
    rst_n = 1'b0;
    sw    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check_zero("reset_hold");
      sw = ~sw;
    end
    // Release reset with the switch held: press on the first cycle only
    sw = 1'b1;
    tick(1);
    rst_n = 1'b1;
    expect_ev(cyc + 1, E_PRESS);
    tick(1);
    check_held(1'b1, "held_after_reset");
    tick(4);
    sw = 1'b0;
    r = cyc + 1;
    expect_ev(r, E_REL);
    expect_ev(r + GAP_N, E_CLICK);
    tick(1);
    check_held(1'b0, "held_after_release");
    tick(20);

    // 2. Short press: click exactly GAP_N cycles after release
    sw = 1'b1;
    expect_ev(cyc + 1, E_PRESS);
    tick(5);
    sw = 1'b0;
    r = cyc + 1;
    expect_ev(r, E_REL);
    expect_ev(r + GAP_N, E_CLICK);
    tick(20);

    // 3. Double click: press 5, release 4, press 5, release
    sw = 1'b1;
    expect_ev(cyc + 1, E_PRESS);
    tick(5);
    sw = 1'b0;
    expect_ev(cyc + 1, E_REL);
    tick(4);
    sw = 1'b1;
    expect_ev(cyc + 1, E_PRESS | E_DBL);
    tick(5);
    sw = 1'b0;
    expect_ev(cyc + 1, E_REL);
    tick(20);

    // 4. Long hold: long 20 cycles after press, no click after release
    sw = 1'b1;
    p = cyc + 1;
    expect_ev(p, E_PRESS);
    expect_ev(p + LONG_N, E_LONG);
`ifdef BUTTON_REPEAT_EN
    expect_ev(p + LONG_N + REP_N, E_REP);
    expect_ev(p + LONG_N + 2 * REP_N, E_REP);
`endif
    tick(32);
    check_held(1'b1, "held_long");
    sw = 1'b0;
    expect_ev(cyc + 1, E_REL);
    tick(20);

    // 5a. Fall sampled exactly when the long threshold is reached: short path
    sw = 1'b1;
    p = cyc + 1;
    expect_ev(p, E_PRESS);
    tick(LONG_N);
    sw = 1'b0;
    r = cyc + 1;
    expect_ev(r, E_REL);
    expect_ev(r + GAP_N, E_CLICK);
    tick(GAP_N + 10);

    // 5b. Second press sampled exactly on the gap expiry: double wins
    sw = 1'b1;
    expect_ev(cyc + 1, E_PRESS);
    tick(3);
    sw = 1'b0;
    r = cyc + 1;
    expect_ev(r, E_REL);
    tick(GAP_N);
    sw = 1'b1;
    expect_ev(cyc + 1, E_PRESS | E_DBL);
    tick(3);
    sw = 1'b0;
    expect_ev(cyc + 1, E_REL);
    tick(20);

    // 6a. Reset in the middle of the gap: pending click discarded
    sw = 1'b1;
    expect_ev(cyc + 1, E_PRESS);
    tick(3);
    sw = 1'b0;
    expect_ev(cyc + 1, E_REL);
    tick(4);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_gap");
    tick(3);
    rst_n = 1'b1;
    tick(25);

    // 6b. Reset while long-held: no repeat and no release afterwards
    sw = 1'b1;
    p = cyc + 1;
    expect_ev(p, E_PRESS);
    expect_ev(p + LONG_N, E_LONG);
    tick(22);
    rst_n = 1'b0;
    sw    = 1'b0;
    #1;
    check_zero("reset_mid_long");
    tick(3);
    rst_n = 1'b1;
    tick(20);

    tick(2);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL pending_event cyc=%0d actual=none required=%b", e.at, e.bits);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_button_event_decoder
`default_nettype wire
